// File: rtl/syn_gpu_line_drawer_if.sv
// Job/pixel bus between the GPU job dispatcher, the line drawer and the pixel writer.
interface syn_gpu_line_drawer_if #(
  parameter int unsigned P_X_W     = 10,
  parameter int unsigned P_Y_W     = 9,
  parameter int unsigned P_COLOR_W = 8
);
  logic                 job_valid_i;
  logic                 job_ready_o;
  logic [P_X_W-1:0]     job_x0_i;
  logic [P_Y_W-1:0]     job_y0_i;
  logic [P_X_W-1:0]     job_x1_i;
  logic [P_Y_W-1:0]     job_y1_i;
  logic [P_COLOR_W-1:0] job_color_i;
  logic                 pxl_valid_o;
  logic                 pxl_ready_i;
  logic [P_X_W-1:0]     pxl_x_o;
  logic [P_Y_W-1:0]     pxl_y_o;
  logic [P_COLOR_W-1:0] pxl_color_o;
  logic                 busy_o;
  logic                 job_done_o;

  // Dispatcher / pixel-writer side
  modport master (
    output job_valid_i, job_x0_i, job_y0_i, job_x1_i, job_y1_i, job_color_i, pxl_ready_i,
    input  job_ready_o, pxl_valid_o, pxl_x_o, pxl_y_o, pxl_color_o, busy_o, job_done_o
  );

  // Line drawer side
  modport slave (
    input  job_valid_i, job_x0_i, job_y0_i, job_x1_i, job_y1_i, job_color_i, pxl_ready_i,
    output job_ready_o, pxl_valid_o, pxl_x_o, pxl_y_o, pxl_color_o, busy_o, job_done_o
  );
endinterface

// File: rtl/syn_gpu_line_drawer.sv
// Bresenham line rasteriser: one LINE job in, one pixel write per cycle out,
// points outside the canvas are skipped (one cycle each) without a pixel write.
module syn_gpu_line_drawer #(
  parameter int unsigned P_X_W      = 10,
  parameter int unsigned P_Y_W      = 9,
  parameter int unsigned P_CANVAS_W = 640,
  parameter int unsigned P_CANVAS_H = 480,
  parameter int unsigned P_COLOR_W  = 8
) (
  input logic                  clk_ir,
  input logic                  rst_ih,
  syn_gpu_line_drawer_if.slave bus
);

  localparam int unsigned L_E_W  = P_X_W + 2;
  localparam int unsigned L_E2_W = P_X_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;

  state_t                   state_q, state_d;
  logic [P_X_W-1:0]         cx_q, cx_d, x1_q, x1_d;
  logic [P_Y_W-1:0]         cy_q, cy_d, y1_q, y1_d;
  logic [P_COLOR_W-1:0]     color_q, color_d;
  logic signed [L_E_W-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                     sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic                     valid_q, valid_d, ready_q, ready_d, busy_q, busy_d;

  logic [P_X_W-1:0]         abs_x;
  logic [P_Y_W-1:0]         abs_y;
  logic signed [L_E2_W-1:0] e2, dx_e, dy_e;
  logic signed [L_E_W-1:0]  add_x, add_y;
  logic                     step_x, step_y, step, last, done_c;

  function automatic logic in_canvas(input logic [P_X_W-1:0] x, input logic [P_Y_W-1:0] y);
    return (32'(x) < P_CANVAS_W) && (32'(y) < P_CANVAS_H);
  endfunction

  // Bresenham decision terms and step qualification
  always_comb begin
    abs_x  = (x1_q >= cx_q) ? (x1_q - cx_q) : (cx_q - x1_q);
    abs_y  = (y1_q >= cy_q) ? (y1_q - cy_q) : (cy_q - y1_q);
    e2     = {err_q, 1'b0};
    dx_e   = {dx_q[L_E_W-1], dx_q};
    dy_e   = {dy_q[L_E_W-1], dy_q};
    step_x = (e2 >= dy_e);
    step_y = (e2 <= dx_e);
    add_x  = step_x ? dy_q : L_E_W'(0);
    add_y  = step_y ? dx_q : L_E_W'(0);
    last   = (cx_q == x1_q) && (cy_q == y1_q);
    // A clipped point presents no pixel, so it advances without waiting for ready
    step   = (state_q == S_DRAW) && (!valid_q || bus.pxl_ready_i);
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    color_d  = color_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    done_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.job_valid_i) begin
          state_d = S_SETUP;
          cx_d    = bus.job_x0_i;
          cy_d    = bus.job_y0_i;
          x1_d    = bus.job_x1_i;
          y1_d    = bus.job_y1_i;
          color_d = bus.job_color_i;
        end
      end
      S_SETUP: begin
        state_d  = S_DRAW;
        dx_d     = L_E_W'(abs_x);
        dy_d     = L_E_W'(0) - L_E_W'(abs_y);
        err_d    = L_E_W'(abs_x) - L_E_W'(abs_y);
        sx_neg_d = !(cx_q < x1_q);
        sy_neg_d = !(cy_q < y1_q);
      end
      S_DRAW: begin
        if (step) begin
          if (last) begin
            state_d = S_IDLE;
            done_c  = 1'b1;
          end else begin
            err_d = err_q + add_x + add_y;
            if (step_x) cx_d = sx_neg_q ? (cx_q - P_X_W'(1)) : (cx_q + P_X_W'(1));
            if (step_y) cy_d = sy_neg_q ? (cy_q - P_Y_W'(1)) : (cy_q + P_Y_W'(1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_DRAW) && in_canvas(cx_d, cy_d);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      state_q  <= S_IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      color_q  <= color_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.job_ready_o = ready_q;
  assign bus.busy_o      = busy_q;
  assign bus.pxl_valid_o = valid_q;
  assign bus.pxl_x_o     = cx_q;
  assign bus.pxl_y_o     = cy_q;
  assign bus.pxl_color_o = color_q;
  assign bus.job_done_o  = done_c;

endmodule

// File: tb/tb_syn_gpu_line_drawer.sv
// Directed bench for the line drawer: table of jobs with expected pixel streams,
// plus hand-written backpressure and mid-job reset sequences.
module tb_syn_gpu_line_drawer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  syn_gpu_line_drawer_if bus ();

  syn_gpu_line_drawer dut (
    .clk_ir (clk),
    .rst_ih (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]       x0, x1;
    logic [8:0]       y0, y1;
    logic [7:0]       col;
    int               n;
    logic [7:0][9:0]  ex;
    logic [7:0][8:0]  ey;
    logic [7:0]       ev;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int x0, input int y0, input int x1, input int y1, input int col);
    vec_t v;
    v.x0 = 10'(x0); v.y0 = 9'(y0); v.x1 = 10'(x1); v.y1 = 9'(y1);
    v.col = 8'(col); v.n = 0; v.ex = '0; v.ey = '0; v.ev = '0;
    return v;
  endfunction

  task automatic add_pt(inout vec_t v, input int x, input int y, input bit vl);
    v.ex[v.n] = 10'(x);
    v.ey[v.n] = 9'(y);
    v.ev[v.n] = vl;
    v.n++;
  endtask

  // Present a job, let it be accepted, check SETUP; returns just after the first DRAW edge
  task automatic start_job(input vec_t v, input string tag);
    bus.job_x0_i    = v.x0;
    bus.job_y0_i    = v.y0;
    bus.job_x1_i    = v.x1;
    bus.job_y1_i    = v.y1;
    bus.job_color_i = v.col;
    bus.job_valid_i = 1'b1;
    @(negedge clk);
    chk({tag, " ready_before_accept"}, 32'(bus.job_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.job_valid_i = 1'b0;
    @(negedge clk);
    chk({tag, " setup_ready"}, 32'(bus.job_ready_o), 32'd0);
    chk({tag, " setup_busy"}, 32'(bus.busy_o), 32'd1);
    chk({tag, " setup_valid"}, 32'(bus.pxl_valid_o), 32'd0);
    @(posedge clk); #1;
  endtask

  // Run a whole job with pxl_ready_i held high and compare every DRAW cycle
  task automatic run_job(input vec_t v, input string tag);
    bus.pxl_ready_i = 1'b1;
    start_job(v, tag);
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      chk($sformatf("%s p%0d valid", tag, i), 32'(bus.pxl_valid_o), 32'(v.ev[i]));
      chk($sformatf("%s p%0d x", tag, i), 32'(bus.pxl_x_o), 32'(v.ex[i]));
      chk($sformatf("%s p%0d y", tag, i), 32'(bus.pxl_y_o), 32'(v.ey[i]));
      chk($sformatf("%s p%0d color", tag, i), 32'(bus.pxl_color_o), 32'(v.col));
      chk($sformatf("%s p%0d done", tag, i), 32'(bus.job_done_o), 32'(i == v.n - 1));
      chk($sformatf("%s p%0d busy", tag, i), 32'(bus.busy_o), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, " after_ready"}, 32'(bus.job_ready_o), 32'd1);
    chk({tag, " after_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, " after_valid"}, 32'(bus.pxl_valid_o), 32'd0);
    chk({tag, " after_done"}, 32'(bus.job_done_o), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    int   acc;
    logic [7:0] bp_rdy;
    logic [7:0][9:0] bp_x;

    n_checks = 0;
    n_fail   = 0;

    // Horizontal line
    v = mk(0, 0, 3, 0, 8'hA5);
    add_pt(v, 0, 0, 1); add_pt(v, 1, 0, 1); add_pt(v, 2, 0, 1); add_pt(v, 3, 0, 1);
    vecs[0] = v;
    // Steep line drawn in reverse
    v = mk(2, 5, 0, 0, 8'h3C);
    add_pt(v, 2, 5, 1); add_pt(v, 2, 4, 1); add_pt(v, 1, 3, 1);
    add_pt(v, 1, 2, 1); add_pt(v, 0, 1, 1); add_pt(v, 0, 0, 1);
    vecs[1] = v;
    // Degenerate single point
    v = mk(7, 7, 7, 7, 8'hFF);
    add_pt(v, 7, 7, 1);
    vecs[2] = v;
    // Crossing the right canvas edge
    v = mk(638, 0, 641, 0, 8'h12);
    add_pt(v, 638, 0, 1); add_pt(v, 639, 0, 1); add_pt(v, 640, 0, 0); add_pt(v, 641, 0, 0);
    vecs[3] = v;
    // Diagonal, no backpressure
    v = mk(10, 10, 12, 12, 8'h81);
    add_pt(v, 10, 10, 1); add_pt(v, 11, 11, 1); add_pt(v, 12, 12, 1);
    vecs[4] = v;

    bus.job_valid_i = 1'b0;
    bus.job_x0_i    = '0;
    bus.job_y0_i    = '0;
    bus.job_x1_i    = '0;
    bus.job_y1_i    = '0;
    bus.job_color_i = '0;
    bus.pxl_ready_i = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset ready", 32'(bus.job_ready_o), 32'd1);
    chk("reset valid", 32'(bus.pxl_valid_o), 32'd0);
    chk("reset busy", 32'(bus.busy_o), 32'd0);
    chk("reset done", 32'(bus.job_done_o), 32'd0);
    chk("reset x", 32'(bus.pxl_x_o), 32'd0);
    chk("reset y", 32'(bus.pxl_y_o), 32'd0);
    chk("reset color", 32'(bus.pxl_color_o), 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 5; k++) run_job(vecs[k], $sformatf("vec%0d", k));

    // Backpressure: ready low for 3 cycles while (11,11) is presented
    bp_rdy = 8'b0011_0001;
    bp_x   = '0;
    bp_x[0] = 10'd10; bp_x[1] = 10'd11; bp_x[2] = 10'd11;
    bp_x[3] = 10'd11; bp_x[4] = 10'd11; bp_x[5] = 10'd12;
    acc = 0;
    bus.pxl_ready_i = 1'b1;
    start_job(vecs[4], "bp");
    for (int i = 0; i < 6; i++) begin
      bus.pxl_ready_i = bp_rdy[i];
      @(negedge clk);
      chk($sformatf("bp c%0d valid", i), 32'(bus.pxl_valid_o), 32'd1);
      chk($sformatf("bp c%0d x", i), 32'(bus.pxl_x_o), 32'(bp_x[i]));
      chk($sformatf("bp c%0d y", i), 32'(bus.pxl_y_o), 32'(bp_x[i]));
      chk($sformatf("bp c%0d color", i), 32'(bus.pxl_color_o), 32'h81);
      chk($sformatf("bp c%0d done", i), 32'(bus.job_done_o), 32'(i == 5));
      if (bus.pxl_valid_o && bus.pxl_ready_i) acc++;
      @(posedge clk); #1;
    end
    bus.pxl_ready_i = 1'b1;
    chk("bp accepted_count", 32'(acc), 32'd3);
    @(negedge clk);
    chk("bp after_ready", 32'(bus.job_ready_o), 32'd1);
    chk("bp after_valid", 32'(bus.pxl_valid_o), 32'd0);
    @(posedge clk); #1;

    // Reset during the 3rd pixel of a long line, then a fresh job
    v = mk(0, 0, 20, 0, 8'h5A);
    start_job(v, "rst");
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst = 1'b1;
      @(negedge clk);
      chk($sformatf("rst p%0d x", i), 32'(bus.pxl_x_o), 32'(i));
      chk($sformatf("rst p%0d valid", i), 32'(bus.pxl_valid_o), 32'd1);
      chk($sformatf("rst p%0d done", i), 32'(bus.job_done_o), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst post valid", 32'(bus.pxl_valid_o), 32'd0);
    chk("rst post busy", 32'(bus.busy_o), 32'd0);
    chk("rst post ready", 32'(bus.job_ready_o), 32'd1);
    chk("rst post done", 32'(bus.job_done_o), 32'd0);
    chk("rst post x", 32'(bus.pxl_x_o), 32'd0);
    @(posedge clk); #1;

    v = mk(5, 5, 6, 5, 8'hC3);
    add_pt(v, 5, 5, 1); add_pt(v, 6, 5, 1);
    run_job(v, "fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
